// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types, counter width and width helper for the FIFO write arbiter.
package fifo_arb_pkg;
    typedef enum logic {ARB_IDLE, ARB_BURST} arb_state_t;
    localparam int CNT_W = 16;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction
endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// fifo_wr_arbiter_if: requester valid/ready handshakes plus the fifo_mem write and status port.
interface fifo_wr_arbiter_if #(parameter int N_REQ = 4, parameter int DW = 8);
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ*DW-1:0] req_data;
    logic [N_REQ-1:0]    req_ready;
    logic                fifo_wr;
    logic [DW-1:0]       fifo_data_in;
    logic                fifo_full;
    logic                fifo_pop;
    modport master (
        output req_valid, req_last, req_data, fifo_full, fifo_pop,
        input  req_ready, fifo_wr, fifo_data_in
    );
    modport slave (
        input  req_valid, req_last, req_data, fifo_full, fifo_pop,
        output req_ready, fifo_wr, fifo_data_in
    );
endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search for the first set req bit after index last.
module rr_pick import fifo_arb_pkg::*; #(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic         any,
    output logic [W-1:0] idx
);
    // Scan farthest-first so the nearest candidate after last overwrites the rest.
    always_comb begin
        any = |req;
        idx = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) idx = W'((int'(last) + k) % N);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: credit-tracked round-robin write arbiter with bounded bursts for fifo_mem.
// Defining FIFO_ARB_STATS_EN adds grant_cnt, a saturating beat counter per requester.
module fifo_wr_arbiter import fifo_arb_pkg::*; #(
    parameter int N_REQ     = 4,
    parameter int DW        = 8,
    parameter int DEPTH     = 16,
    parameter int BURST_MAX = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    fifo_wr_arbiter_if.slave             bus,
    output logic [clog2(DEPTH+1)-1:0]    occupancy,
    output logic [clog2(N_REQ)-1:0]      grant_id,
    output logic                         overflow_err
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [N_REQ*CNT_W-1:0]       grant_cnt
`endif
);
    localparam int OW = clog2(DEPTH + 1);
    localparam int GW = clog2(N_REQ);
    localparam int BW = clog2(BURST_MAX + 1);

    arb_state_t    state;
    logic [GW-1:0] last_grant;
    logic [BW-1:0] beats;
    logic [BW-1:0] beats_nxt;
    logic          pick_any;
    logic [GW-1:0] pick_idx;
    logic [GW-1:0] sel;
    logic [DW-1:0] sel_data;
    logic          credit_ok;
    logic          hs;
    logic          pop_ok;
    logic          burst_done;

    rr_pick #(.N(N_REQ), .W(GW)) u_pick (
        .req  (bus.req_valid),
        .last (last_grant),
        .any  (pick_any),
        .idx  (pick_idx)
    );

    // In a burst the owner (last_grant) holds the port even while stalled on credit.
    always_comb begin
        credit_ok     = occupancy < OW'(DEPTH);
        sel           = (state == ARB_BURST) ? last_grant : pick_idx;
        bus.req_ready = (rst_n && credit_ok && (state == ARB_BURST || pick_any)) ? N_REQ'(1) << sel : '0;
        hs            = |(bus.req_ready & bus.req_valid);
        sel_data      = '0;
        for (int i = 0; i < N_REQ; i++)
            if (sel == GW'(i)) sel_data = bus.req_data[i*DW +: DW];
        beats_nxt  = beats + BW'(1);
        burst_done = bus.req_last[sel] || beats_nxt == BW'(BURST_MAX);
        pop_ok     = bus.fifo_pop && occupancy != '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= ARB_IDLE;
            last_grant       <= GW'(N_REQ - 1);
            beats            <= '0;
            bus.fifo_wr      <= 1'b0;
            bus.fifo_data_in <= '0;
            occupancy        <= '0;
            grant_id         <= '0;
            overflow_err     <= 1'b0;
        end else begin
            bus.fifo_wr <= hs;
            if (hs) begin
                bus.fifo_data_in <= sel_data;
                grant_id         <= sel;
                last_grant       <= sel;
            end
            occupancy <= occupancy + OW'(hs) - OW'(pop_ok);
            if (bus.fifo_wr && bus.fifo_full) overflow_err <= 1'b1;
            if (state == ARB_IDLE) begin
                if (hs && BURST_MAX > 1 && !bus.req_last[sel]) begin
                    state <= ARB_BURST;
                    beats <= BW'(1);
                end
            end else if (!bus.req_valid[sel]) begin
                state <= ARB_IDLE;
                beats <= '0;
            end else if (hs) begin
                beats <= beats_nxt;
                if (burst_done) begin
                    state <= ARB_IDLE;
                    beats <= '0;
                end
            end
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [CNT_W-1:0] cnt [N_REQ];

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++)
            if (!rst_n) cnt[i] <= '0;
            else if (hs && sel == GW'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_cnt
        assign grant_cnt[i*CNT_W +: CNT_W] = cnt[i];
    end
`endif
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that lets `N_REQ` independent producers share the single write port of the 8-bit `fifo_mem` buffer. It accepts each producer's beats with a valid/ready handshake and tracks FIFO occupancy with its own credit counter, so it never issues a write into a full FIFO. It supports bounded bursts per grant and drives `fifo_mem`'s `wr`/`data_in` from registers.

## Interface
- `N_REQ`, 4: number of requesters; 2..8.
- `DW`, 8: data width; matches `fifo_mem`.
- `DEPTH`, 16: FIFO depth; sets the credit limit.
- `BURST_MAX`, 4: maximum beats per grant; 1 disables bursting.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N_REQ  per-requester beat valid.
- `req_last`  in  N_REQ  per-requester final beat of burst.
- `req_data`  in  N_REQ*DW  requester i's data in bits [i*DW +: DW].
- `req_ready`  out  N_REQ  per-requester accept, combinational.
- `fifo_wr`  out  1  write strobe to `fifo_mem`, registered.
- `fifo_data_in`  out  DW  write data, registered.
- `fifo_full`  in  1  `fifo_mem` full flag; used only for the error check.
- `fifo_pop`  in  1  actual pop (`rd & ~fifo_empty`) from the read side.
- `occupancy`  out  clog2(DEPTH+1)  committed entries, including an in-flight write.
- `grant_id`  out  clog2(N_REQ)  requester of the most recent accepted beat.
- `overflow_err`  out  1  sticky; set when `fifo_wr` and `fifo_full` are both high.

## Operation
- **Credit:** `credit_ok = occupancy < DEPTH`.
- **Occupancy update:** +1 on any handshake, -1 on `fifo_pop`. Both in the same cycle leaves it unchanged. A pop at occupancy 0 is ignored.
- **FSM IDLE:**
  - The winner is the first valid requester searching from `last_grant+1`, wrapping modulo `N_REQ`.
  - `req_ready[winner] = credit_ok`; all other ready bits are 0.
  - On handshake, `last_grant <= winner`.
  - If `BURST_MAX > 1` and `!req_last[winner]`, go to BURST with `beats = 1`; otherwise stay in IDLE.
- **FSM BURST:**
  - Only the owner can get ready: `req_ready[owner] = credit_ok`. All other requesters are blocked, even with no credit; the owner keeps the grant while stalled.
  - Each handshake increments `beats`.
  - Exit to IDLE after a handshake carrying `req_last`, or after a handshake that makes `beats == BURST_MAX`.
  - Also exit to IDLE on any cycle where the owner's `req_valid` is low.
- **Write path:** a handshake registers `fifo_wr = 1`, `fifo_data_in` = the accepted data, and `grant_id` = the requester, for exactly one following cycle. `fifo_wr` deasserts unless another handshake occurred.
- **`overflow_err`:** set when `fifo_wr & fifo_full`. Cleared only by reset. The write is still issued; this is a consistency alarm.
- **`req_valid` stability:** requesters hold `req_valid` and `req_data` until handshake. The arbiter does not check this.

## Timing
- Reset values: `fifo_wr = 0`, `fifo_data_in = 0`, `occupancy = 0`, `grant_id = 0`, `overflow_err = 0`, state IDLE, `last_grant = N_REQ-1` (so requester 0 wins first), `beats = 0`.
- Latency: handshake in cycle t gives `fifo_wr` in cycle t+1. `occupancy` reflects the beat at t+1.
- Throughput: one beat per cycle while credit remains.
- At `occupancy == DEPTH`: `req_ready` is all 0. A pop in cycle t allows a handshake in t+1.
- Reset mid-burst or with a write in flight: state returns to IDLE at the next edge and the pending `fifo_wr` is dropped. `fifo_mem` must be reset together with the arbiter.

## Configuration
- `FIFO_ARB_STATS_EN` defined:
  - Adds output `grant_cnt` (N_REQ*16), one saturating 16-bit beat counter per requester.
  - Counters increment on that requester's handshake and reset to 0.
- Not defined: no port, no counters. Arbitration behaviour is identical either way.

## Structure
- Shared package `fifo_arb_pkg`:
  - FSM state enum `ARB_IDLE` / `ARB_BURST`.
  - `CNT_W = 16`.
  - `clog2` helper function.
- One sub-module, `rr_pick`: a combinational round-robin priority search (`req`, `last`) -> (`any`, `idx`).

## Test plan
- **Reset:** hold `rst_n = 0` for 2 cycles with all `req_valid = 1` -> every output 0 and `req_ready = 0` during reset; requester 0 gets ready on the first cycle after release.
- **Single beat:** requester 1 sends 0x11 with `last = 1` -> `fifo_wr = 1`, `fifo_data_in = 0x11`, `grant_id = 1` one cycle later; `occupancy = 1`.
- **Fairness:** `BURST_MAX = 1`, all four requesters always valid -> grant order 0,1,2,3,0,1; `grant_cnt` equal per requester with `FIFO_ARB_STATS_EN` defined.
- **Full FIFO:** 16 beats with no pops -> `occupancy = 16` and `req_ready = 0`; one `fifo_pop` -> exactly one more write, occupancy back to 16, `overflow_err` stays 0.
- **Simultaneous push and pop:** at occupancy 5, a handshake and `fifo_pop` in the same cycle -> occupancy stays 5.
- **Burst:** requester 2 valid with `last = 0` and requester 3 valid, `BURST_MAX = 4` -> four consecutive beats from 2, then requester 3 is granted.
